serial_subtractor: RTL and testbench



---
 rtl/sub_pkg.sv | 29 ++
 rtl/fullsub.sv | 20 ++
 rtl/serial_subtractor.sv | 124 ++++++++++++
 tb/tb_serial_subtractor.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
//------------------------------------------------------------------------------
// sub_pkg: shared FSM state type and reference model for the serial subtractor
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Returns {borrow, diff}; diff occupies the low 'width' bits, higher bits are zero.
  function automatic logic [32:0] sub_ref(input int unsigned width,
                                          input logic [31:0]  a,
                                          input logic [31:0]  b,
                                          input logic         bin);
    logic [31:0] mask;
    logic [32:0] full;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    full = {1'b0, a & mask} - {1'b0, b & mask} - {32'd0, bin};
    return {full[32], full[31:0] & mask};
  endfunction

endpackage

`default_nettype wire

// File: rtl/fullsub.sv
//------------------------------------------------------------------------------
// fullsub: one-bit full subtractor cell, d = x - y - c with borrow-out bo
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fullsub (
  input  logic x,
  input  logic y,
  input  logic c,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ c;
  assign bo = (~x & y) | (~x & c) | (y & c);

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
//------------------------------------------------------------------------------
// serial_subtractor: bit-serial WIDTH-bit unsigned a - b - bin, LSB first
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  // Only the upper WIDTH-1 result bits need storage; the newest bit comes from the cell.
  logic [WIDTH-2:0] r_res_sh;
  logic             r_brw;
  logic [CNT_W-1:0] r_cnt;

  logic             w_accept;
  logic             w_last;
  logic             w_d;
  logic             w_bo;
  logic [WIDTH-1:0] w_res_nxt;

  fullsub u_fullsub (
    .x  (r_a_sh[0]),
    .y  (r_b_sh[0]),
    .c  (r_brw),
    .d  (w_d),
    .bo (w_bo)
  );

  assign w_last    = (r_cnt == C_CNT_LAST);
  assign w_res_nxt = {w_d, r_res_sh};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = SHIFT;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh     <= '0;
      r_b_sh     <= '0;
      r_res_sh   <= '0;
      r_brw      <= 1'b0;
      r_cnt      <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else if (w_accept) begin
      r_a_sh <= a;
      r_b_sh <= b;
      r_brw  <= bin;
      r_cnt  <= '0;
    end else if (r_state == SHIFT) begin
      r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
      r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
      r_res_sh <= w_res_nxt[WIDTH-1:1];
      r_brw    <= w_bo;
      r_cnt    <= r_cnt + 1'b1;
      // Results are published only on the final shift and then held.
      if (w_last) begin
        diff       <= w_res_nxt;
        borrow_out <= w_bo;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
//------------------------------------------------------------------------------
// tb_serial_subtractor: scoreboard bench for serial_subtractor (WIDTH = 8)
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_serial_subtractor;
  import sub_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int done_cnt = 0;
  int pushed = 0;
  int busy_run = 0;
  int last_done = 0;
  int prev_done = 0;
  logic [W:0] exp_q[$];
  logic [W:0] e_mon;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .bin        (bin),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_run = 0;
    end else if (done) begin
      done_cnt++;
      prev_done = last_done;
      last_done = cyc;
      check("busy_len", 32'(busy_run), 32'(W));
      busy_run = 0;
      check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e_mon = exp_q.pop_front();
        check("diff", 32'(diff), 32'(e_mon[W-1:0]));
        check("borrow_out", 32'(borrow_out), 32'(e_mon[W]));
      end
    end else if (busy) begin
      busy_run++;
    end
  end

  task automatic push_exp(input logic [W:0] ex);
    exp_q.push_back(ex);
    pushed++;
  endtask

  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tbin, input bit push, input logic [W:0] ex);
    @(negedge clk);
    a = ta; b = tb; bin = tbin; start = 1'b1;
    if (push) push_exp(ex);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3 * W; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", 32'(seen), 32'd1);
  endtask

  task automatic run_ref(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin);
    logic [32:0] r;
    r = sub_ref(W, 32'(ta), 32'(tb), tbin);
    start_op(ta, tb, tbin, 1'b1, {r[32], r[W-1:0]});
    wait_done();
  endtask

  initial begin
    int saved;
    logic [W-1:0] va, vb;

    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_borrow", 32'(borrow_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic directed operations
    start_op(8'h5A, 8'h3C, 1'b0, 1'b1, {1'b0, 8'h1E}); wait_done();
    start_op(8'h00, 8'h01, 1'b0, 1'b1, {1'b1, 8'hFF}); wait_done();
    start_op(8'h10, 8'h0F, 1'b1, 1'b1, {1'b0, 8'h00}); wait_done();

    // start and operands disturbed mid-SHIFT are ignored
    start_op(8'hAA, 8'h55, 1'b0, 1'b1, {1'b0, 8'h55});
    repeat (2) @(negedge clk);
    a = 8'hFF; b = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // start held high: back-to-back operations
    @(negedge clk);
    a = 8'h33; b = 8'h11; bin = 1'b0; start = 1'b1;
    push_exp({1'b0, 8'h22});
    @(posedge clk);
    #1 a = 8'h01; b = 8'h02; bin = 1'b0; push_exp({1'b1, 8'hFF});
    repeat (9) @(posedge clk);
    #1 a = 8'h80; b = 8'h7F; bin = 1'b1; push_exp({1'b0, 8'h00});
    repeat (9) @(posedge clk);
    #1 a = 8'h00; b = 8'h00; bin = 1'b1; push_exp({1'b1, 8'hFF});
    repeat (9) @(posedge clk);
    #1 start = 1'b0;
    wait_done();
    check("done_spacing", 32'(last_done - prev_done), 32'd9);

    // Asynchronous reset in the middle of SHIFT
    start_op(8'hF0, 8'h0F, 1'b0, 1'b0, '0);
    repeat (3) @(negedge clk);
    saved = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_diff", 32'(diff), 32'd0);
    check("arst_borrow", 32'(borrow_out), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("no_done_after_rst", 32'(done_cnt), 32'(saved));
    start_op(8'hF0, 8'h0F, 1'b0, 1'b1, {1'b0, 8'hE1}); wait_done();

    // Corner and random sweep against the package model
    for (int ca = 0; ca < 2; ca++)
      for (int cb = 0; cb < 2; cb++)
        for (int ci = 0; ci < 2; ci++) begin
          va = (ca != 0) ? 8'hFF : 8'h00;
          vb = (cb != 0) ? 8'hFF : 8'h00;
          run_ref(va, vb, ci[0]);
        end
    for (int n = 0; n < 992; n++) begin
      va = 8'($urandom_range(0, 255));
      vb = 8'($urandom_range(0, 255));
      run_ref(va, vb, 1'($urandom_range(0, 1)));
    end

    repeat (5) @(negedge clk);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    check("done_count", 32'(done_cnt), 32'(pushed));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
